mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit for the EX stage; successor to the single-cycle combinational-result MDU.
- One result bit per cycle: radix-2 shift-add multiply, restoring divide. Adds multiply-accumulate/subtract, a start/busy/done handshake, a cancel input for pipeline flush, and defined divide-by-zero and overflow results.
- Owns the HI/LO registers. The stall controller uses busy to hold MFHI/MFLO and any new MDU op.

Parameters:
- WIDTH, 32, operand and HI/LO width (>=4, even).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- op  in  4  operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU, 9 MTHI, 10 MTLO; 11-15 treated as NOP
- operand_a  in  WIDTH  rs value (multiplicand/dividend; MTHI/MTLO data)
- operand_b  in  WIDTH  rt value (multiplier/divisor)
- cancel  in  1  flush: abort the in-flight operation
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when HI/LO commit a result
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (reset=0, async): hi=0, lo=0, busy=0, done=0, state=IDLE, all internal registers 0. Deassertion is sampled at the next clk edge.
- States:
  - IDLE -> CALC on an arithmetic op (1-8) with busy=0.
  - CALC runs WIDTH iterations on a counter from WIDTH-1 down to 0.
  - CALC -> FIX when the counter reaches 0.
  - FIX applies sign correction and accumulation, commits HI/LO, returns to IDLE.
- busy is 1 in CALC and FIX. Full latency: busy high for WIDTH+1 cycles. Result is visible on hi/lo, with done=1, in the first cycle busy=0.
- Ops are sampled only when busy=0. Any op presented while busy=1 is ignored; the upstream stall guarantees it is held.
- At start, capture: magnitudes of operands (signed ops), sign flags, op class, and the {hi,lo} snapshot for MADD/MSUB.
- MULT/MULTU: 2*WIDTH product; {hi,lo}=product. Signed ops negate the product in FIX when the signs differ.
- MADD(U)/MSUB(U): {hi,lo} = snapshot +/- product, modulo 2^(2*WIDTH). No saturation.
- DIV/DIVU:
  - lo=quotient, hi=remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - Signed overflow (most-negative / -1): lo=most-negative, hi=0.
- Divide by zero (operand_b=0, DIV or DIVU):
  - Skips CALC, goes IDLE -> FIX; busy high for exactly 1 cycle.
  - lo = all ones, hi = operand_a.
- MTHI/MTLO with busy=0: hi (resp. lo) = operand_a at the edge. busy stays 0 and done stays 0.
- NOP with busy=0: no change.
- cancel=1 while busy:
  - Next edge returns to IDLE, busy=0, done=0, hi/lo keep their pre-operation values.
  - cancel beats completion in FIX.
  - cancel in IDLE suppresses any op sampled that cycle, including MTHI/MTLO.
- hi/lo never change during CALC/FIX; they hold their old values until the FIX commit.
- Async reset mid-operation: immediate return to reset values; the partial result is discarded.
- No combinational path from op/operand inputs to busy, done, hi or lo.

Test Plan:
- Reset: reset=0 mid-MULT -> hi=lo=busy=done=0 immediately. After release, MTLO 0x12345678 -> lo=0x12345678 next edge, hi=0.
- MULT a=0xFFFFFFFE (-2), b=3 -> busy high 33 cycles, then done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=100, b=0 -> busy high exactly 1 cycle, lo=0xFFFFFFFF, hi=100.
- MADD accumulate: MTHI 0, MTLO 0xFFFFFFFF, then MADDU 1*1 -> hi=1, lo=0. Then MSUB 1*2 -> hi=0, lo=0xFFFFFFFE.
- Flush and busy gating: start MULT 5*5, assert cancel at cycle 10 -> busy=0, hi/lo unchanged, no done. Separately, MTHI presented during busy -> hi unaffected.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO ownership: radix-2 shift-add multiply,
// restoring divide, MADD/MSUB accumulation, start/busy/done handshake and flush cancel.
module mdu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2} state_e;
    typedef enum logic [1:0] {K_MUL = 2'd0, K_DIV = 2'd1, K_DZ = 2'd2} kind_e;

    state_e            state_q, state_d;
    kind_e             kind_q, kind_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  opnd_q, opnd_d;
    logic [W2-1:0]     acc_q, acc_d;
    logic [W2-1:0]     snap_q, snap_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic              add_q, add_d;
    logic              sub_q, sub_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;

    logic              is_mul, is_div, is_signed, sign_a, sign_b;
    logic [WIDTH-1:0]  mag_a, mag_b;
    logic [WIDTH:0]    mul_sum, div_trial;
    logic              div_ok;
    logic [W2-1:0]     mul_next, div_next, prod, res;
    logic [WIDTH-1:0]  quo, rem;

    // Operand decode and magnitude extraction at start
    always_comb begin
        is_mul    = op_i inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
        is_div    = op_i inside {OP_DIV, OP_DIVU};
        is_signed = op_i inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
        sign_a    = is_signed & operand_a_i[WIDTH-1];
        sign_b    = is_signed & operand_b_i[WIDTH-1];
        mag_a     = sign_a ? (~operand_a_i + WIDTH'(1)) : operand_a_i;
        mag_b     = sign_b ? (~operand_b_i + WIDTH'(1)) : operand_b_i;
    end

    // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide
    always_comb begin
        mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_trial = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
        div_ok    = ~div_trial[WIDTH];
        div_next  = {(div_ok ? div_trial[WIDTH-1:0] : {acc_q[W2-2:WIDTH], acc_q[WIDTH-1]}),
                     acc_q[WIDTH-2:0], div_ok};
        prod      = neg_q ? (~acc_q + W2'(1)) : acc_q;
        quo       = neg_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
        rem       = rneg_q ? (~acc_q[W2-1:WIDTH] + WIDTH'(1)) : acc_q[W2-1:WIDTH];
        unique case (kind_q)
            K_MUL: begin
                if (add_q)      res = snap_q + prod;
                else if (sub_q) res = snap_q - prod;
                else            res = prod;
            end
            K_DIV:   res = {rem, quo};
            default: res = acc_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            kind_q  <= K_MUL;
            cnt_q   <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            snap_q  <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            add_q   <= 1'b0;
            sub_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            snap_q  <= snap_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            add_q   <= add_d;
            sub_q   <= sub_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state: start/capture in IDLE, one bit per CALC cycle, commit in FIX
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        snap_d  = snap_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        add_d   = add_q;
        sub_d   = sub_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (!cancel_i) begin
                    if (is_mul || is_div) begin
                        neg_d  = sign_a ^ sign_b;
                        rneg_d = sign_a;
                        add_d  = op_i inside {OP_MADD, OP_MADDU};
                        sub_d  = op_i inside {OP_MSUB, OP_MSUBU};
                        snap_d = {hi_q, lo_q};
                        cnt_d  = CW'(WIDTH - 1);
                        if (is_div && operand_b_i == '0) begin
                            kind_d  = K_DZ;
                            acc_d   = {operand_a_i, {WIDTH{1'b1}}};
                            state_d = S_FIX;
                        end else if (is_mul) begin
                            kind_d  = K_MUL;
                            acc_d   = {{WIDTH{1'b0}}, mag_b};
                            opnd_d  = mag_a;
                            state_d = S_CALC;
                        end else begin
                            kind_d  = K_DIV;
                            acc_d   = {{WIDTH{1'b0}}, mag_a};
                            opnd_d  = mag_b;
                            state_d = S_CALC;
                        end
                    end else if (op_i == OP_MTHI) begin
                        hi_d = operand_a_i;
                    end else if (op_i == OP_MTLO) begin
                        lo_d = operand_a_i;
                    end
                end
            end
            S_CALC: begin
                if (cancel_i) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = (kind_q == K_MUL) ? mul_next : div_next;
                    if (cnt_q == '0) state_d = S_FIX;
                    else             cnt_d   = cnt_q - CW'(1);
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!cancel_i) begin
                    hi_d   = res[W2-1:WIDTH];
                    lo_d   = res[WIDTH-1:0];
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed test-plan scenarios plus randomized ops against an
// arithmetic reference model of HI/LO, latency, done pulse, cancel and reset.
module tb_mdu_iter;
    localparam int unsigned W = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [3:0]    op_i;
    logic [W-1:0]  operand_a_i, operand_b_i;
    logic          cancel_i;
    logic          busy_o, done_o;
    logic [W-1:0]  hi_o, lo_o;

    int            vectors = 0;
    int            miscompares = 0;
    logic [63:0]   exp_hl = '0;

    mdu_iter #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .op_i(op_i),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .cancel_i(cancel_i),
        .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
        longint      sa, sb, sq, sr;
        logic [63:0] sp, up, q64, r64;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sp = 64'(sa * sb);
        up = {32'd0, a} * {32'd0, b};
        case (op)
            4'd1: return sp;
            4'd2: return up;
            4'd3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                sq  = sa / sb;
                sr  = sa % sb;
                q64 = 64'(sq);
                r64 = 64'(sr);
                return {r64[31:0], q64[31:0]};
            end
            4'd4: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            4'd5:  return hl + sp;
            4'd6:  return hl + up;
            4'd7:  return hl - sp;
            4'd8:  return hl - up;
            4'd9:  return {a, hl[31:0]};
            4'd10: return {hl[63:32], a};
            default: return hl;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'(($urandom_range(0, 40)) - 20);
            default: return $urandom();
        endcase
    endfunction

    // Issue one op at a negedge, follow it to completion, check hold, latency and result.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inject);
        logic [63:0] exp;
        int          exp_busy;
        int          n;
        exp = model(op, a, b, exp_hl);
        if (op >= 4'd1 && op <= 4'd8) exp_busy = ((op == 4'd3 || op == 4'd4) && b == 0) ? 1 : W + 1;
        else                           exp_busy = 0;
        op_i = op; operand_a_i = a; operand_b_i = b;
        @(negedge clk_i);
        op_i = 4'd0; operand_a_i = $urandom(); operand_b_i = $urandom();
        n = 0;
        while (busy_o === 1'b1 && n < 200) begin
            n++;
            vectors++;
            if (done_o !== 1'b0 || hi_o !== exp_hl[63:32] || lo_o !== exp_hl[31:0]) begin
                miscompares++;
                $display("FAIL hold op=%0d cyc=%0d: done=%b hi=%h lo=%h, required done=0 hi=%h lo=%h",
                         op, n, done_o, hi_o, lo_o, exp_hl[63:32], exp_hl[31:0]);
            end
            if (inject && n == 3) begin
                op_i = 4'd9; operand_a_i = $urandom();
            end else begin
                op_i = 4'd0;
            end
            @(negedge clk_i);
        end
        op_i = 4'd0;
        vectors++;
        if (n !== exp_busy) begin
            miscompares++;
            $display("FAIL latency op=%0d: busy cycles=%0d, required %0d", op, n, exp_busy);
        end
        vectors++;
        if (done_o !== (exp_busy > 0)) begin
            miscompares++;
            $display("FAIL done op=%0d: done=%b, required %b", op, done_o, exp_busy > 0);
        end
        vectors++;
        if (hi_o !== exp[63:32] || lo_o !== exp[31:0]) begin
            miscompares++;
            $display("FAIL result op=%0d a=%h b=%h: hi=%h lo=%h, required hi=%h lo=%h",
                     op, a, b, hi_o, lo_o, exp[63:32], exp[31:0]);
        end
        exp_hl = exp;
    endtask

    // Start an op and assert cancel in busy cycle 'at' (1 = first busy cycle).
    task automatic run_cancel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input int at);
        int n;
        op_i = op; operand_a_i = a; operand_b_i = b;
        @(negedge clk_i);
        op_i = 4'd0;
        n = 1;
        while (n < at) begin
            @(negedge clk_i);
            n++;
        end
        vectors++;
        if (busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL cancel_pre op=%0d at=%0d: busy=%b, required 1", op, at, busy_o);
        end
        cancel_i = 1'b1;
        @(negedge clk_i);
        cancel_i = 1'b0;
        vectors++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || hi_o !== exp_hl[63:32] || lo_o !== exp_hl[31:0]) begin
            miscompares++;
            $display("FAIL cancel op=%0d at=%0d: busy=%b done=%b hi=%h lo=%h, required 0 0 %h %h",
                     op, at, busy_o, done_o, hi_o, lo_o, exp_hl[63:32], exp_hl[31:0]);
        end
        @(negedge clk_i);
        vectors++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || hi_o !== exp_hl[63:32] || lo_o !== exp_hl[31:0]) begin
            miscompares++;
            $display("FAIL cancel_after op=%0d at=%0d: busy=%b done=%b hi=%h lo=%h", op, at,
                     busy_o, done_o, hi_o, lo_o);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        vectors++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || hi_o !== '0 || lo_o !== '0) begin
            miscompares++;
            $display("FAIL reset_init: busy=%b done=%b hi=%h lo=%h, required all 0", busy_o, done_o, hi_o, lo_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        exp_hl = '0;
        run_op(4'd9, 32'hA5A5_0001, 32'h0, 1'b0);
        run_op(4'd10, 32'h5A5A_0002, 32'h0, 1'b0);
        op_i = 4'd1; operand_a_i = 32'h0000_1234; operand_b_i = 32'h0000_0056;
        @(negedge clk_i);
        op_i = 4'd0;
        repeat (6) @(negedge clk_i);
        vectors++;
        if (busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_busy_pre: busy=%b, required 1", busy_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        vectors++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || hi_o !== '0 || lo_o !== '0) begin
            miscompares++;
            $display("FAIL reset_async: busy=%b done=%b hi=%h lo=%h, required all 0", busy_o, done_o, hi_o, lo_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        exp_hl = '0;
        @(negedge clk_i);
        run_op(4'd10, 32'h1234_5678, 32'h0, 1'b0);
        vectors++;
        if (lo_o !== 32'h1234_5678 || hi_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mtlo: hi=%h lo=%h, required 00000000 12345678", hi_o, lo_o);
        end
    endtask

    task automatic test_directed();
        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        vectors++;
        if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFA) begin
            miscompares++;
            $display("FAIL mult_neg: hi=%h lo=%h, required ffffffff fffffffa", hi_o, lo_o);
        end
        run_op(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
        vectors++;
        if (hi_o !== 32'h0000_0002 || lo_o !== 32'hFFFF_FFFA) begin
            miscompares++;
            $display("FAIL multu: hi=%h lo=%h, required 00000002 fffffffa", hi_o, lo_o);
        end
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        vectors++;
        if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFD) begin
            miscompares++;
            $display("FAIL div_neg: hi=%h lo=%h, required ffffffff fffffffd", hi_o, lo_o);
        end
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        vectors++;
        if (hi_o !== 32'h0 || lo_o !== 32'h8000_0000) begin
            miscompares++;
            $display("FAIL div_ovf: hi=%h lo=%h, required 00000000 80000000", hi_o, lo_o);
        end
        run_op(4'd4, 32'd100, 32'd0, 1'b0);
        vectors++;
        if (hi_o !== 32'd100 || lo_o !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL divu_zero: hi=%h lo=%h, required 00000064 ffffffff", hi_o, lo_o);
        end
    endtask

    task automatic test_madd();
        run_op(4'd9, 32'h0, 32'h0, 1'b0);
        run_op(4'd10, 32'hFFFF_FFFF, 32'h0, 1'b0);
        run_op(4'd6, 32'd1, 32'd1, 1'b0);
        vectors++;
        if (hi_o !== 32'd1 || lo_o !== 32'd0) begin
            miscompares++;
            $display("FAIL maddu: hi=%h lo=%h, required 00000001 00000000", hi_o, lo_o);
        end
        run_op(4'd7, 32'd1, 32'd2, 1'b0);
        vectors++;
        if (hi_o !== 32'd0 || lo_o !== 32'hFFFF_FFFE) begin
            miscompares++;
            $display("FAIL msub: hi=%h lo=%h, required 00000000 fffffffe", hi_o, lo_o);
        end
        run_op(4'd5, 32'hFFFF_FFFD, 32'd7, 1'b1);
    endtask

    task automatic test_cancel();
        run_cancel(4'd1, 32'd5, 32'd5, 10);
        run_cancel(4'd3, 32'hFFFF_FF00, 32'd9, W + 1);
        run_cancel(4'd4, 32'd77, 32'd0, 1);
        op_i = 4'd9; operand_a_i = 32'hDEAD_BEEF; cancel_i = 1'b1;
        @(negedge clk_i);
        op_i = 4'd0; cancel_i = 1'b0;
        vectors++;
        if (hi_o !== exp_hl[63:32] || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL cancel_idle_mthi: hi=%h busy=%b, required %h 0", hi_o, busy_o, exp_hl[63:32]);
        end
        op_i = 4'd2; operand_a_i = 32'd3; operand_b_i = 32'd4; cancel_i = 1'b1;
        @(negedge clk_i);
        op_i = 4'd0; cancel_i = 1'b0;
        vectors++;
        if (busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL cancel_idle_mult: busy=%b, required 0", busy_o);
        end
        run_op(4'd1, 32'd5, 32'd5, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_op(4'd2, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        run_op(4'd3, 32'h8765_4321, 32'h0000_0123, 1'b0);
        run_op(4'd8, 32'h0000_FFFF, 32'h0001_0000, 1'b0);
        run_op(4'd3, 32'h1, 32'h0, 1'b0);
        @(negedge clk_i);
        vectors++;
        if (done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: done=%b, required 0", done_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            run_op(4'($urandom_range(0, 15)), pick(), pick(), ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        rst_ni = 1'b0; op_i = 4'd0; operand_a_i = '0; operand_b_i = '0; cancel_i = 1'b0;
        @(negedge clk_i);
        test_reset();
        test_directed();
        test_madd();
        test_cancel();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
